// File: rtl/sram_req_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_req_arb                                               |
// | Description : Two-host arbiter in front of a single SRAM request port.   |
// |               Host 0 is the core path, host 1 the boot loader/DMA path.  |
// |               One request is granted per cycle. The issuer of each read  |
// |               is queued in an ID FIFO so that every in-order SRAM        |
// |               response is routed back to the host that asked for it.     |
// | Config      : `define SRAM_ARB_RR_EN selects round-robin arbitration;     |
// |               left undefined, host 0 has fixed priority.                 |
// | Ports       : clk_i, rst_i        clock, synchronous active-high reset   |
// |               hN_req/we/addr/wdata/wmask_i   host N request (N=0,1)      |
// |               hN_gnt_o             host N request accepted this cycle    |
// |               hN_rvalid/rdata/rerror_o       host N read response        |
// |               sram_req/we/addr/wdata/wmask_o SRAM request port           |
// |               sram_gnt_i, sram_rvalid/rdata/rerror_i  SRAM handshake     |
// |               busy_o               a read is outstanding                 |
// |               err_o                sticky: response with no read queued  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_req_arb #(
    parameter int SramAw         = 14,
    parameter int MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              h0_req_i,
    input  logic              h0_we_i,
    input  logic [SramAw-1:0] h0_addr_i,
    input  logic [31:0]       h0_wdata_i,
    input  logic [3:0]        h0_wmask_i,
    output logic              h0_gnt_o,
    output logic              h0_rvalid_o,
    output logic [31:0]       h0_rdata_o,
    output logic [1:0]        h0_rerror_o,

    input  logic              h1_req_i,
    input  logic              h1_we_i,
    input  logic [SramAw-1:0] h1_addr_i,
    input  logic [31:0]       h1_wdata_i,
    input  logic [3:0]        h1_wmask_i,
    output logic              h1_gnt_o,
    output logic              h1_rvalid_o,
    output logic [31:0]       h1_rdata_o,
    output logic [1:0]        h1_rerror_o,

    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [SramAw-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    output logic [3:0]        sram_wmask_o,
    input  logic              sram_gnt_i,
    input  logic              sram_rvalid_i,
    input  logic [31:0]       sram_rdata_i,
    input  logic [1:0]        sram_rerror_i,

    output logic              busy_o,
    output logic              err_o
);

    // Pointers are at least one bit wide so a depth-1 FIFO still has a legal
    // index; the ID store is sized to the full pointer range so every pointer
    // value selects a real bit, only the first MaxOutstanding slots are used.
    localparam int c_CNT_W = $clog2(MaxOutstanding + 1);
    localparam int c_PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int c_SLOTS = 1 << c_PTR_W;

    localparam logic [c_PTR_W-1:0] c_LAST_SLOT = c_PTR_W'(MaxOutstanding - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(MaxOutstanding);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_SLOTS-1:0] r_ids;      // issuer of each queued read (0=h0, 1=h1)
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_err;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic              w_any;
    logic              w_sel;       // winning host index
    logic              w_sel_we;
    logic [SramAw-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_sel_wmask;
    logic              w_full;
    logic              w_empty;
    logic              w_blocked;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_head;

    assign w_any = h0_req_i | h1_req_i;

`ifdef SRAM_ARB_RR_EN
    // Host that received the most recent accepted grant; reset value 1 makes
    // host 0 the winner of the first contention.
    logic r_last;

    always_comb begin
        w_sel = 1'b0;
        if (h0_req_i && h1_req_i) begin
            w_sel = ~r_last;
        end else begin
            w_sel = h1_req_i;
        end
    end

    // Only an accepted grant moves the pointer; blocked or ungranted cycles
    // leave the rotation where it is.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_sel;
        end
    end
`else
    always_comb begin
        w_sel = 1'b0;
        if (!h0_req_i && h1_req_i) begin
            w_sel = 1'b1;
        end
    end
`endif

    always_comb begin
        w_sel_we    = h0_we_i;
        w_sel_addr  = h0_addr_i;
        w_sel_wdata = h0_wdata_i;
        w_sel_wmask = h0_wmask_i;
        if (w_sel) begin
            w_sel_we    = h1_we_i;
            w_sel_addr  = h1_addr_i;
            w_sel_wdata = h1_wdata_i;
            w_sel_wmask = h1_wmask_i;
        end
    end

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // A read winner with a full FIFO stalls the whole port: the loser is not
    // promoted, which keeps the arbitration decision independent of FIFO
    // occupancy. Full is judged on registered state, so a same-cycle pop
    // does not unblock it.
    assign w_blocked = w_any & ~w_sel_we & w_full;

    assign sram_req_o   = w_any & ~w_blocked;
    assign sram_we_o    = sram_req_o & w_sel_we;
    assign sram_addr_o  = sram_req_o ? w_sel_addr  : '0;
    assign sram_wdata_o = sram_req_o ? w_sel_wdata : '0;
    assign sram_wmask_o = sram_req_o ? w_sel_wmask : '0;

    assign w_accept = sram_req_o & sram_gnt_i;
    assign h0_gnt_o = w_accept & ~w_sel;
    assign h1_gnt_o = w_accept &  w_sel;

    // ------------------------------------------------------------------
    // ID FIFO
    // ------------------------------------------------------------------
    assign w_push = w_accept & ~w_sel_we;
    assign w_pop  = sram_rvalid_i & ~w_empty;
    assign w_head = r_ids[r_rd_ptr];

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
        f_next_ptr = (ptr == c_LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ids    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wr_ptr] <= w_sel;
                r_wr_ptr        <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // A response with nothing queued has no owner; flag it and drop it.
            if (sram_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing (zero-latency pass-through to the queued issuer)
    // ------------------------------------------------------------------
    assign h0_rvalid_o = w_pop & ~w_head;
    assign h1_rvalid_o = w_pop &  w_head;
    assign h0_rdata_o  = h0_rvalid_o ? sram_rdata_i  : '0;
    assign h0_rerror_o = h0_rvalid_o ? sram_rerror_i : '0;
    assign h1_rdata_o  = h1_rvalid_o ? sram_rdata_i  : '0;
    assign h1_rerror_o = h1_rvalid_o ? sram_rerror_i : '0;

    assign busy_o = ~w_empty;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_req_arb                                            |
// | Description : Self-checking bench for sram_req_arb. Directed scenarios   |
// |               with literal expectations, then randomized traffic checked |
// |               each cycle against a queue-based behavioural model.        |
// | Config      : honours `define SRAM_ARB_RR_EN like the design.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sram_req_arb;

    localparam int AW   = 14;
    localparam int MAXO = 2;

`ifdef SRAM_ARB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          h0_req_i, h0_we_i, h1_req_i, h1_we_i;
    logic [AW-1:0] h0_addr_i, h1_addr_i;
    logic [31:0]   h0_wdata_i, h1_wdata_i;
    logic [3:0]    h0_wmask_i, h1_wmask_i;
    logic          h0_gnt_o, h0_rvalid_o, h1_gnt_o, h1_rvalid_o;
    logic [31:0]   h0_rdata_o, h1_rdata_o;
    logic [1:0]    h0_rerror_o, h1_rerror_o;
    logic          sram_req_o, sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [3:0]    sram_wmask_o;
    logic          sram_gnt_i, sram_rvalid_i;
    logic [31:0]   sram_rdata_i;
    logic [1:0]    sram_rerror_i;
    logic          busy_o, err_o;

    sram_req_arb #(.SramAw(AW), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .h0_req_i(h0_req_i), .h0_we_i(h0_we_i), .h0_addr_i(h0_addr_i),
        .h0_wdata_i(h0_wdata_i), .h0_wmask_i(h0_wmask_i), .h0_gnt_o(h0_gnt_o),
        .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o), .h0_rerror_o(h0_rerror_o),
        .h1_req_i(h1_req_i), .h1_we_i(h1_we_i), .h1_addr_i(h1_addr_i),
        .h1_wdata_i(h1_wdata_i), .h1_wmask_i(h1_wmask_i), .h1_gnt_o(h1_gnt_o),
        .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o), .h1_rerror_o(h1_rerror_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_wmask_o(sram_wmask_o),
        .sram_gnt_i(sram_gnt_i), .sram_rvalid_i(sram_rvalid_i),
        .sram_rdata_i(sram_rdata_i), .sram_rerror_i(sram_rerror_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of read owners, a sticky error flag and
    // the host granted last. Checked and advanced on every falling edge.
    // ------------------------------------------------------------------
    bit        mq[$];
    bit        m_err;
    bit        m_last;
    bit        m_valid = 1'b0;

    bit        e_win, e_we, e_req, e_acc, e_pop, e_head;
    bit [AW-1:0] e_addr;
    bit [31:0] e_wdata;
    bit [3:0]  e_wmask;

    always @(negedge clk_i) begin
        if (m_valid) begin
            if (h0_req_i && h1_req_i) e_win = c_RR ? (m_last ? 1'b0 : 1'b1) : 1'b0;
            else                      e_win = h1_req_i;
            e_we    = e_win ? h1_we_i    : h0_we_i;
            e_addr  = e_win ? h1_addr_i  : h0_addr_i;
            e_wdata = e_win ? h1_wdata_i : h0_wdata_i;
            e_wmask = e_win ? h1_wmask_i : h0_wmask_i;
            e_req   = (h0_req_i || h1_req_i) && !(!e_we && mq.size() == MAXO);
            e_acc   = e_req && sram_gnt_i;
            e_pop   = sram_rvalid_i && mq.size() != 0;
            e_head  = (mq.size() != 0) ? mq[0] : 1'b0;

            chk("m_sram_req", sram_req_o, e_req);
            chk("m_h0_gnt",   h0_gnt_o,   e_acc && !e_win);
            chk("m_h1_gnt",   h1_gnt_o,   e_acc &&  e_win);
            if (e_req || !(h0_req_i || h1_req_i)) begin
                chk("m_sram_we",    sram_we_o,    e_req ? e_we    : 1'b0);
                chk("m_sram_addr",  sram_addr_o,  e_req ? e_addr  : '0);
                chk("m_sram_wdata", sram_wdata_o, e_req ? e_wdata : '0);
                chk("m_sram_wmask", sram_wmask_o, e_req ? e_wmask : '0);
            end
            chk("m_h0_rvalid", h0_rvalid_o, e_pop && !e_head);
            chk("m_h1_rvalid", h1_rvalid_o, e_pop &&  e_head);
            chk("m_h0_rdata",  h0_rdata_o,  (e_pop && !e_head) ? sram_rdata_i  : '0);
            chk("m_h1_rdata",  h1_rdata_o,  (e_pop &&  e_head) ? sram_rdata_i  : '0);
            chk("m_h0_rerror", h0_rerror_o, (e_pop && !e_head) ? sram_rerror_i : '0);
            chk("m_h1_rerror", h1_rerror_o, (e_pop &&  e_head) ? sram_rerror_i : '0);
            chk("m_busy",      busy_o,      mq.size() != 0);
            chk("m_err",       err_o,       m_err);

            if (!rst_i) begin
                if (e_pop) void'(mq.pop_front());
                else if (sram_rvalid_i) m_err = 1'b1;
                if (e_acc && !e_we) mq.push_back(e_win);
                if (e_acc) m_last = e_win;
            end
        end
        if (rst_i) begin
            mq.delete();
            m_err   = 1'b0;
            m_last  = 1'b1;
            m_valid = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        h0_req_i = 0; h0_we_i = 0; h0_addr_i = '0; h0_wdata_i = '0; h0_wmask_i = '0;
        h1_req_i = 0; h1_we_i = 0; h1_addr_i = '0; h1_wdata_i = '0; h1_wmask_i = '0;
        sram_gnt_i = 1; sram_rvalid_i = 0; sram_rdata_i = '0; sram_rerror_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1; tick(); rst_i = 0;
    endtask

    initial begin
        idle();
        rst_i = 1;
        tick(); tick();
        rst_i = 0;
        #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err",  err_o,  1'b0);
        chk("rst_req",  sram_req_o, 1'b0);
        tick();

        // Single read from host 0, response two cycles after issue.
        h0_req_i = 1; h0_addr_i = 14'h010;
        #2;
        chk("rd_h0_gnt",  h0_gnt_o,    1'b1);
        chk("rd_addr",    sram_addr_o, 14'h010);
        tick();
        h0_req_i = 0;
        #2 chk("rd_busy", busy_o, 1'b1);
        tick();
        sram_rvalid_i = 1; sram_rdata_i = 32'hDEADBEEF;
        #2;
        chk("rd_h0_rvalid", h0_rvalid_o, 1'b1);
        chk("rd_h0_rdata",  h0_rdata_o,  32'hDEADBEEF);
        chk("rd_h1_rvalid", h1_rvalid_o, 1'b0);
        tick();
        sram_rvalid_i = 0; sram_rdata_i = '0;
        #2 chk("rd_busy_done", busy_o, 1'b0);
        tick();

        // Both hosts read for four cycles; responses drain one per cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            h0_req_i = 1; h0_addr_i = AW'(16'h100 + i);
            h1_req_i = 1; h1_addr_i = AW'(16'h200 + i);
            sram_rvalid_i = (i > 0); sram_rdata_i = 32'hA000 + i;
            #2;
            chk("cont_h0_gnt", h0_gnt_o, c_RR ? ((i % 2) == 0) : 1'b1);
            chk("cont_h1_gnt", h1_gnt_o, c_RR ? ((i % 2) == 1) : 1'b0);
            if (i == 2) chk("cont_route_h1", h1_rvalid_o, c_RR);
            tick();
        end
        h0_req_i = 0; h1_req_i = 0;
        sram_rvalid_i = 1; sram_rdata_i = 32'hA004;
        tick();
        sram_rvalid_i = 0;
        #2 chk("cont_drained", busy_o, 1'b0);
        tick();

        // Host 1 issues three reads with the FIFO depth at two.
        for (int i = 0; i < 6; i++) begin
            h1_req_i = 1; h1_addr_i = AW'(16'h300 + (i < 2 ? i : 2));
            sram_rvalid_i = (i == 4); sram_rdata_i = 32'h5555_0000;
            #2;
            chk("full_h1_gnt", h1_gnt_o, (i < 2) || (i == 5));
            if (i == 4) chk("full_pop_h1", h1_rvalid_o, 1'b1);
            tick();
        end
        h1_req_i = 0;
        sram_rvalid_i = 1;
        tick(); tick();
        sram_rvalid_i = 0;
        #2 chk("full_drained", busy_o, 1'b0);
        tick();

        // Host 1 write at the top of the address space.
        h1_req_i = 1; h1_we_i = 1; h1_addr_i = 14'h3FFF;
        h1_wdata_i = 32'h12345678; h1_wmask_i = 4'b0101;
        #2;
        chk("wr_wmask", sram_wmask_o, 4'b0101);
        chk("wr_addr",  sram_addr_o,  14'h3FFF);
        chk("wr_we",    sram_we_o,    1'b1);
        chk("wr_gnt",   h1_gnt_o,     1'b1);
        tick();
        idle();
        #2;
        chk("wr_no_push", busy_o,      1'b0);
        chk("wr_no_rv0",  h0_rvalid_o, 1'b0);
        chk("wr_no_rv1",  h1_rvalid_o, 1'b0);
        tick();

        // Response with nothing outstanding.
        sram_rvalid_i = 1; sram_rdata_i = 32'hBAD0BAD0;
        #2;
        chk("orph_err_pre", err_o,       1'b0);
        chk("orph_rv0",     h0_rvalid_o, 1'b0);
        chk("orph_rv1",     h1_rvalid_o, 1'b0);
        tick();
        sram_rvalid_i = 0;
        #2 chk("orph_err", err_o, 1'b1);
        tick(); tick(); tick();
        chk("orph_sticky", err_o, 1'b1);

        // Reset with two reads in flight, then a stray response.
        do_reset();
        h0_req_i = 1; h0_addr_i = 14'h001;
        tick();
        h0_addr_i = 14'h002;
        tick();
        h0_req_i = 0;
        #2 chk("mid_busy_pre", busy_o, 1'b1);
        do_reset();
        #2;
        chk("mid_busy_post", busy_o, 1'b0);
        chk("mid_err_post",  err_o,  1'b0);
        sram_rvalid_i = 1;
        tick();
        sram_rvalid_i = 0;
        #2 chk("mid_err_set", err_o, 1'b1);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_i         = ($urandom_range(199) == 0);
            h0_req_i      = $urandom_range(1);
            h0_we_i       = ($urandom_range(2) == 0);
            h0_addr_i     = AW'($urandom);
            h0_wdata_i    = $urandom;
            h0_wmask_i    = 4'($urandom);
            h1_req_i      = $urandom_range(1);
            h1_we_i       = ($urandom_range(2) == 0);
            h1_addr_i     = AW'($urandom);
            h1_wdata_i    = $urandom;
            h1_wmask_i    = 4'($urandom);
            sram_gnt_i    = ($urandom_range(3) != 0);
            sram_rvalid_i = (mq.size() != 0) ? $urandom_range(1) : ($urandom_range(39) == 0);
            sram_rdata_i  = $urandom;
            sram_rerror_i = 2'($urandom);
            tick();
        end
        rst_i = 0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
